// File: rtl/ahblite_timer.sv
// rtl/ahblite_timer.sv - AHB-lite slave down-counting timer with 8-bit prescaler and level IRQ
module ahblite_timer #(
    parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        IRQ
);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_VALUE  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } err_state_t;

    err_state_t state_q, state_d;

    logic        dp_valid;
    logic        dp_write;
    logic [1:0]  dp_addr;

    logic        ctrl_en;
    logic        ctrl_ie;
    logic        ctrl_reload;
    logic [7:0]  ctrl_prescale;
    logic [31:0] load_q;
    logic [31:0] value_q;
    logic        if_q;
    logic [7:0]  presc_cnt;

    logic        addr_phase;
    logic        xfer_legal;
    logic        accept_ok;
    logic        accept_bad;
    logic        wr_en;
    logic        rd_en;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_status;
    logic        tick;
    logic        if_set;
    logic        hreadyout_fsm;
    logic        hresp_fsm;
    logic [31:0] rdata;

    logic        unused_ok;
    assign unused_ok = &{1'b0, HADDR[31:4], HTRANS[0]};

    // ERR1 stalls the bus, so no new address phase can be taken there.
    assign addr_phase = HSEL & HREADY & HTRANS[1] & (state_q != ERR1);
    assign xfer_legal = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00);
    assign accept_ok  = addr_phase & xfer_legal;
    assign accept_bad = addr_phase & ~xfer_legal;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 2'd0;
        end else begin
            dp_valid <= accept_ok;
            dp_write <= HWRITE;
            dp_addr  <= HADDR[3:2];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hreadyout_fsm = 1'b1;
        hresp_fsm     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_bad) state_d = ERR1;
            end
            ERR1: begin
                hreadyout_fsm = 1'b0;
                hresp_fsm     = 1'b1;
                state_d       = ERR2;
            end
            ERR2: begin
                hresp_fsm = 1'b1;
                state_d   = accept_bad ? ERR1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_en     = dp_valid & dp_write;
    assign rd_en     = dp_valid & ~dp_write;
    assign wr_ctrl   = wr_en && (dp_addr == A_CTRL);
    assign wr_load   = wr_en && (dp_addr == A_LOAD);
    assign wr_status = wr_en && (dp_addr == A_STATUS);

    assign tick   = ctrl_en && (presc_cnt == ctrl_prescale);
    assign if_set = tick && (value_q == '0);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            presc_cnt <= 8'd0;
        end else if (!ctrl_en || tick) begin
            presc_cnt <= 8'd0;
        end else begin
            presc_cnt <= presc_cnt + 8'd1;
        end
    end

    // A CTRL or LOAD write in a tick cycle takes priority and suppresses the tick's VALUE/EN effect.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_en       <= 1'b0;
            ctrl_ie       <= 1'b0;
            ctrl_reload   <= 1'b0;
            ctrl_prescale <= 8'd0;
            load_q        <= RESET_LOAD;
            value_q       <= RESET_LOAD;
        end else if (wr_ctrl) begin
            ctrl_en       <= HWDATA[0];
            ctrl_ie       <= HWDATA[1];
            ctrl_reload   <= HWDATA[2];
            ctrl_prescale <= HWDATA[15:8];
        end else if (wr_load) begin
            load_q  <= HWDATA;
            value_q <= HWDATA;
        end else if (tick) begin
            if (value_q != '0) begin
                value_q <= value_q - 32'd1;
            end else if (ctrl_reload) begin
                value_q <= load_q;
            end else begin
                ctrl_en <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            if_q <= 1'b0;
        end else if (if_set) begin
            if_q <= 1'b1;
        end else if (wr_status && HWDATA[0]) begin
            if_q <= 1'b0;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (rd_en) begin
            case (dp_addr)
                A_CTRL:   rdata = {16'd0, ctrl_prescale, 5'd0, ctrl_reload, ctrl_ie, ctrl_en};
                A_LOAD:   rdata = load_q;
                A_VALUE:  rdata = value_q;
                A_STATUS: rdata = {31'd0, if_q};
                default:  rdata = 32'd0;
            endcase
        end
    end

    assign HREADYOUT = HRESET | hreadyout_fsm;
    assign HRESP     = ~HRESET & hresp_fsm;
    assign HRDATA    = HRESET ? 32'd0 : rdata;
    assign IRQ       = if_q & ctrl_ie;

endmodule
